// File: rtl/tone_gen_pkg.sv
// Shared definitions for the piano tone path: FSM encoding, note frequencies
// and the half-period formula that the key-to-tone selector also uses.
package tone_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam int unsigned CLK_HZ_DEFAULT = 48000000;

  localparam int unsigned A4_HZ = 440;
  localparam int unsigned G4_HZ = 392;
  localparam int unsigned F4_HZ = 349;
  localparam int unsigned C4_HZ = 262;

  // Number of extra cycles per half period: half period = result + 1 cycles.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned note_hz);
    return clk_hz / note_hz / 2 - 1;
  endfunction

endpackage

// File: rtl/tone_gen_halfperiod_counter.sv
// Loadable down-counter timing one half period; it parks at zero and
// reports zero so the FSM can reload it on the last cycle of a phase.
module halfperiod_counter #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tone_gen.sv
// Square-wave speaker driver: HIGH and LOW phases of tone+1 cycles each,
// starting and stopping only on full-period boundaries.
module tone_gen
  import tone_gen_pkg::*;
#(
  parameter int unsigned INPUT = CLK_HZ_DEFAULT,
  parameter int          WIDTH = $clog2(half_period(INPUT, C4_HZ))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] tone,
  output logic             speaker,
  output logic             active,
  output logic             cycle_done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tone_q, tone_d;
  logic             speaker_q, speaker_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  logic             cnt_load;
  logic [WIDTH-1:0] cnt_value;
  logic             cnt_zero;

  halfperiod_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .value (cnt_value),
    .zero  (cnt_zero)
  );

  // tone is only latched at a period start so HIGH and LOW share one value.
  always_comb begin
    state_d   = state_q;
    tone_d    = tone_q;
    cnt_load  = 1'b0;
    cnt_value = tone_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          tone_d    = tone;
          cnt_load  = 1'b1;
          cnt_value = tone;
          state_d   = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          cnt_load  = 1'b1;
          cnt_value = tone_q;
          state_d   = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_zero) begin
          done_d = 1'b1;
          if (en) begin
            tone_d    = tone;
            cnt_load  = 1'b1;
            cnt_value = tone;
            state_d   = ST_HIGH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    speaker_d = (state_d == ST_HIGH);
    active_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tone_q    <= '0;
      speaker_q <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tone_q    <= tone_d;
      speaker_q <= speaker_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign speaker    = speaker_q;
  assign active     = active_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen: directed scenarios plus random en/tone/rst traffic,
// checked cycle by cycle against a period-position model and a period-length scoreboard.
module tb_tone_gen;

  localparam int TW = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic [TW-1:0] tone;
  logic          speaker;
  logic          active;
  logic          cycle_done;

  tone_gen #(
    .WIDTH(TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .tone       (tone),
    .speaker    (speaker),
    .active     (active),
    .cycle_done (cycle_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a period is 2*(tone+1) cycles; position < tone+1 means speaker high.
  bit m_act;
  int m_tone;
  int m_pos;
  bit m_done;

  // Scoreboard: expected full-period lengths, pushed when a period starts.
  logic [31:0] exp_q[$];
  int          dut_run;

  task automatic step();
    bit exp_spk;
    @(posedge clk);
    if (rst) begin
      m_act  = 1'b0;
      m_tone = 0;
      m_pos  = 0;
      m_done = 1'b0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (!m_act) begin
        if (en) begin
          m_act  = 1'b1;
          m_tone = int'(tone);
          m_pos  = 0;
          exp_q.push_back(32'(2 * (m_tone + 1)));
        end
      end else if (m_pos == 2 * (m_tone + 1) - 1) begin
        m_done = 1'b1;
        if (en) begin
          m_tone = int'(tone);
          m_pos  = 0;
          exp_q.push_back(32'(2 * (m_tone + 1)));
        end else begin
          m_act = 1'b0;
        end
      end else begin
        m_pos++;
      end
    end
    #1;
    exp_spk = m_act && (m_pos <= m_tone);
    check("speaker", 32'(speaker), 32'(exp_spk));
    check("active", 32'(active), 32'(m_act));
    check("cycle_done", 32'(cycle_done), 32'(m_done));
    if (rst) begin
      dut_run = 0;
    end else begin
      if (cycle_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("period_len_unexpected", 32'(dut_run), 32'hFFFF_FFFF);
        end else begin
          check("period_len", 32'(dut_run), exp_q[0]);
          void'(exp_q.pop_front());
        end
        dut_run = 0;
      end
      if (active === 1'b1) dut_run++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    tone    = TW'(3);
    dut_run = 0;

    // reset held with en=1, tone=3
    run(3);
    rst = 1'b0;

    // steady play tone=3
    run(24);

    // tone change 3->1 inside the HIGH phase of a period
    step();
    step();
    tone = TW'(1);
    run(16);

    // minimum tone
    tone = TW'(0);
    run(12);

    // stop mid-HIGH: let a tone=3 period start, drop en after 2 HIGH cycles
    tone = TW'(3);
    run(3);
    while (!(m_act && m_pos == 1)) step();
    en = 1'b0;
    run(12);

    // reset mid-LOW, then restart at the widest tone
    en = 1'b1;
    run(6);
    rst = 1'b1;
    step();
    rst  = 1'b0;
    tone = TW'(15);
    run(70);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      tone = TW'($urandom_range(0, 15));
      rst  = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    en  = 1'b0;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
